// File: rtl/cmd_scheduler.sv
// Shares one CPU command port between two requesters. Each requester has its own FIFO, and an arbiter
// loads one head entry into a held output register that stays stable for a whole FETCH/DECODE/EXEC slot.
module cmd_scheduler #(
  parameter int unsigned      CMD_W    = 7,
  parameter int unsigned      DEPTH    = 2,
  parameter int unsigned      HOLD_CYC = 2,
  parameter logic [CMD_W-1:0] NOP_CMD  = 7'b0000100,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] req0_cmd,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CMD_W-1:0] req1_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             pri_fixed,
  input  logic             fetch_en,
  input  logic             invalid_data,
  input  logic             err_clr,
  output logic [CMD_W-1:0] cmd_out,
  output logic             cmd_real,
  output logic             grant_id,
  output logic             err0,
  output logic             err1,
  output logic             seq_err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FC_W  = PTR_W + 1;
  localparam int unsigned HC_W  = $clog2(HOLD_CYC + 1);
  localparam logic [FC_W-1:0] FULL_CNT  = FC_W'(DEPTH);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYC - 1);

  typedef enum logic {ST_SLOT = 1'b0, ST_HOLD = 1'b1} state_e;

  logic [1:0][DEPTH-1:0][CMD_W-1:0] mem_q, mem_d;
  logic [1:0][PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][FC_W-1:0]             fcnt_q, fcnt_d;
  logic [1:0][CMD_W-1:0]            req_cmd_s, head_s;
  logic [1:0]                       req_valid_s, full_s, push_s, pop_s, avail_s;
  logic                             retire_s, sel_s, do_sel_s, seq_set_s;
  logic [1:0]                       err_set_s;

  state_e           state_q, state_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CMD_W-1:0] cmd_out_q, cmd_out_d;
  logic             cmd_real_q, cmd_real_d;
  logic             grant_id_q, grant_id_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       err_q, err_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // Requester inputs, FIFO occupancy flags and accepted pushes.
  always_comb begin
    req_cmd_s   = {req1_cmd, req0_cmd};
    req_valid_s = {req1_valid, req0_valid};
    for (int i = 0; i < 2; i++) begin
      full_s[i] = (fcnt_q[i] == FULL_CNT);
      push_s[i] = req_valid_s[i] && !full_s[i];
    end
  end

  // Retire pops the owner's head; arbitration sees the heads left after that pop but before this edge's pushes.
  always_comb begin
    retire_s = (state_q == ST_HOLD) && !fetch_en && (hold_cnt_q == HOLD_LAST) && cmd_real_q;
    pop_s    = {retire_s && grant_id_q, retire_s && !grant_id_q};
    for (int i = 0; i < 2; i++) begin
      avail_s[i] = pop_s[i] ? (fcnt_q[i] > FC_W'(1)) : (fcnt_q[i] != '0);
      head_s[i]  = mem_q[i][rd_ptr_q[i] + PTR_W'(pop_s[i])];
    end
    if (avail_s == 2'b11) begin
      sel_s = pri_fixed ? 1'b0 : ~last_grant_q;
    end else begin
      sel_s = avail_s[1];
    end
  end

  // FIFO next-state: a full FIFO drops the push even when the same edge pops.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = req_cmd_s[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1'b1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop_s[i]);
      fcnt_d[i]   = fcnt_q[i] + FC_W'(push_s[i]) - FC_W'(pop_s[i]);
    end
  end

  // Slot sequencing, output load, error attribution and retire counting.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cmd_out_d    = cmd_out_q;
    cmd_real_d   = cmd_real_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    retire_cnt_d = retire_cnt_q + CNT_W'(retire_s);
    do_sel_s     = 1'b0;
    seq_set_s    = 1'b0;
    err_set_s    = 2'b00;
    case (state_q)
      ST_SLOT: begin
        if (fetch_en) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else if (!cmd_real_q && (avail_s != 2'b00)) begin
          do_sel_s = 1'b1;
        end else begin
          do_sel_s = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cmd_real_q && invalid_data) begin
          err_set_s[grant_id_q] = 1'b1;
        end else begin
          err_set_s = 2'b00;
        end
        if (fetch_en) begin
          seq_set_s  = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d  = ST_SLOT;
          do_sel_s = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1'b1);
        end
      end
      default: begin
        state_d    = ST_SLOT;
        hold_cnt_d = '0;
      end
    endcase
    if (do_sel_s && (avail_s != 2'b00)) begin
      cmd_out_d    = head_s[sel_s];
      cmd_real_d   = 1'b1;
      grant_id_d   = sel_s;
      last_grant_d = sel_s;
    end else if (do_sel_s) begin
      cmd_out_d  = NOP_CMD;
      cmd_real_d = 1'b0;
    end else begin
      cmd_out_d = cmd_out_q;
    end
    // A set in the same cycle as err_clr wins.
    err_d     = err_set_s | (err_q & {2{~err_clr}});
    seq_err_d = seq_set_s | (seq_err_q & ~err_clr);
  end

  // State registers; reset discards queued and held commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
      state_q      <= ST_SLOT;
      hold_cnt_q   <= '0;
      cmd_out_q    <= NOP_CMD;
      cmd_real_q   <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 2'b00;
      seq_err_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cmd_out_q    <= cmd_out_d;
      cmd_real_q   <= cmd_real_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      seq_err_q    <= seq_err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign req0_ready = ~full_s[0];
  assign req1_ready = ~full_s[1];
  assign cmd_out    = cmd_out_q;
  assign cmd_real   = cmd_real_q;
  assign grant_id   = grant_id_q;
  assign err0       = err_q[0];
  assign err1       = err_q[1];
  assign seq_err    = seq_err_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler: idle NOP, single issue, arbitration order, FIFO full drop,
// error attribution and clear precedence, fetch sequencing error and mid-slot reset.
module tb_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] req0_cmd, req1_cmd;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic       pri_fixed, fetch_en, invalid_data, err_clr;
  logic [6:0] cmd_out;
  logic       cmd_real, grant_id, err0, err1, seq_err;
  logic [7:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_cmd(req0_cmd), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_cmd(req1_cmd), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .pri_fixed(pri_fixed), .fetch_en(fetch_en), .invalid_data(invalid_data), .err_clr(err_clr),
    .cmd_out(cmd_out), .cmd_real(cmd_real), .grant_id(grant_id),
    .err0(err0), .err1(err1), .seq_err(seq_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full instruction slot: fetch, two held cycles, reload at the end of the third cycle.
  task automatic run_slot(input string tag, input logic [6:0] exp_cmd, input logic exp_gid);
    chk({tag, "_cmd"}, 32'(cmd_out), 32'(exp_cmd));
    chk({tag, "_real"}, 32'(cmd_real), 32'd1);
    chk({tag, "_gid"}, 32'(grant_id), 32'(exp_gid));
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk({tag, "_decode"}, 32'(cmd_out), 32'(exp_cmd));
    tick();
    chk({tag, "_exec"}, 32'(cmd_out), 32'(exp_cmd));
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req0_cmd = 7'h00; req1_cmd = 7'h00; req0_valid = 1'b0; req1_valid = 1'b0;
    pri_fixed = 1'b0; fetch_en = 1'b0; invalid_data = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_cmd", 32'(cmd_out), 32'h04);
    chk("rst_real", 32'(cmd_real), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_errs", 32'({err0, err1, seq_err}), 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'h3);

    // 1: idle, fetch every third cycle
    for (int k = 0; k < 9; k++) begin
      fetch_en = (k % 3 == 0);
      tick();
      chk("idle_cmd", 32'({cmd_real, cmd_out}), 32'h04);
    end
    fetch_en = 1'b0;
    chk("idle_retire", 32'(retire_cnt), 32'd0);

    // 2: single command from req0
    req0_cmd = 7'h21; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chk("t2_not_yet", 32'(cmd_real), 32'd0);
    tick();
    run_slot("t2", 7'h21, 1'b0);
    chk("t2_nop", 32'({cmd_real, cmd_out}), 32'h04);
    chk("t2_retire", 32'(retire_cnt), 32'd1);

    // 3a: round-robin order
    req0_cmd = 7'h10; req0_valid = 1'b1;
    tick();
    req0_cmd = 7'h11; req1_cmd = 7'h50; req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0; req1_cmd = 7'h51;
    tick();
    req1_valid = 1'b0;
    run_slot("rr0", 7'h10, 1'b0);
    run_slot("rr1", 7'h50, 1'b1);
    run_slot("rr2", 7'h11, 1'b0);
    run_slot("rr3", 7'h51, 1'b1);
    chk("rr_nop", 32'({cmd_real, cmd_out}), 32'h04);
    chk("rr_retire", 32'(retire_cnt), 32'd5);

    // 3b: fixed priority order
    pri_fixed = 1'b1;
    req0_cmd = 7'h10; req0_valid = 1'b1;
    tick();
    req0_cmd = 7'h11; req1_cmd = 7'h50; req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0; req1_cmd = 7'h51;
    tick();
    req1_valid = 1'b0;
    run_slot("fp0", 7'h10, 1'b0);
    run_slot("fp1", 7'h11, 1'b0);
    run_slot("fp2", 7'h50, 1'b1);
    run_slot("fp3", 7'h51, 1'b1);
    chk("fp_retire", 32'(retire_cnt), 32'd9);
    pri_fixed = 1'b0;

    // 4: third push into a full FIFO is dropped
    req0_cmd = 7'h31; req0_valid = 1'b1;
    tick();
    chk("full_rdy1", 32'(req0_ready), 32'd1);
    req0_cmd = 7'h32;
    tick();
    chk("full_rdy2", 32'(req0_ready), 32'd0);
    req0_cmd = 7'h33;
    tick();
    req0_valid = 1'b0;
    chk("full_rdy3", 32'(req0_ready), 32'd0);
    run_slot("full0", 7'h31, 1'b0);
    chk("full_rdy_back", 32'(req0_ready), 32'd1);
    run_slot("full1", 7'h32, 1'b0);
    chk("full_drop_nop", 32'({cmd_real, cmd_out}), 32'h04);
    chk("full_retire", 32'(retire_cnt), 32'd11);

    // 5: invalid_data attribution and clear precedence
    req1_cmd = 7'h6C; req1_valid = 1'b1;
    tick();
    req1_cmd = 7'h6D;
    tick();
    req1_valid = 1'b0;
    chk("err_cmd", 32'({grant_id, cmd_out}), 32'hEC);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; invalid_data = 1'b1;
    tick();
    invalid_data = 1'b0;
    chk("err1_set", 32'(err1), 32'd1);
    chk("err0_clear", 32'(err0), 32'd0);
    tick();
    chk("err_next", 32'(cmd_out), 32'h6D);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; invalid_data = 1'b1; err_clr = 1'b1;
    tick();
    invalid_data = 1'b0; err_clr = 1'b0;
    chk("err_set_wins", 32'(err1), 32'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'({err0, err1}), 32'd0);
    invalid_data = 1'b1;
    tick();
    invalid_data = 1'b0;
    chk("err_idle_ignored", 32'({err0, err1}), 32'd0);
    chk("err_retire", 32'(retire_cnt), 32'd13);

    // 6: fetch during HOLD, then reset mid-HOLD
    req0_cmd = 7'h44; req0_valid = 1'b1;
    tick();
    req0_cmd = 7'h45;
    tick();
    req0_valid = 1'b0;
    chk("seq_cmd", 32'(cmd_out), 32'h44);
    fetch_en = 1'b1;
    tick();
    tick();
    fetch_en = 1'b0;
    chk("seq_err_set", 32'(seq_err), 32'd1);
    chk("seq_held1", 32'(cmd_out), 32'h44);
    tick();
    chk("seq_held2", 32'(cmd_out), 32'h44);
    tick();
    chk("seq_reload", 32'({grant_id, cmd_out}), 32'h45);
    chk("seq_retire", 32'(retire_cnt), 32'd14);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_cmd", 32'({cmd_real, cmd_out}), 32'h04);
    chk("mrst_gid", 32'(grant_id), 32'd0);
    chk("mrst_errs", 32'({err0, err1, seq_err}), 32'd0);
    chk("mrst_retire", 32'(retire_cnt), 32'd0);
    chk("mrst_ready", 32'({req0_ready, req1_ready}), 32'h3);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mrst_discard", 32'({cmd_real, cmd_out}), 32'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
